// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for uart_tx: byte request in, serial line and status out.
// tx_start is a request qualified only by the transmitter being idle: a byte is
// accepted on a rising edge where tx_start=1 and tx_busy=0; while tx_busy=1 the
// request is ignored, so tx_busy doubles as the inverse of ready.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start, tx_data,
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data,
    output tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (even, or odd when ODD_PARITY=1).
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic [2:0] dbg_state_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
    $error("uart_tx: CLKS_PER_BIT must be >= 2 and ODD_PARITY must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       bit_end;
  logic [2:0] idx_nxt;

  assign bit_end = (baud_q == BAUD_LAST);
  assign idx_nxt = bit_idx_q + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    // The baud counter free-runs in every non-idle state and wraps on each bit boundary.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          shift_d   = bus.tx_data;
`ifdef UART_TX_PARITY_EN
          par_d     = (ODD_PARITY != 0) ? ~^bus.tx_data : ^bus.tx_data;
`endif
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          baud_d    = '0;
          bit_idx_d = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = idx_nxt;
            tx_d      = shift_q[idx_nxt];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit; expectations follow the
// UART_TX_PARITY_EN setting used for the build.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
  localparam logic [10:0] EXP_AD = 11'h75A;
  localparam logic [10:0] EXP_00 = 11'h400;
  localparam logic [10:0] EXP_F0 = 11'h5E0;
  localparam logic [10:0] EXP_3C = 11'h478;
`else
  localparam int FRAME = 10 * CPB;
  localparam logic [10:0] EXP_AD = 11'h35A;
  localparam logic [10:0] EXP_00 = 11'h200;
  localparam logic [10:0] EXP_F0 = 11'h3E0;
  localparam logic [10:0] EXP_3C = 11'h278;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  uart_tx_if bus ();
  uart_tx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

`ifdef UART_TX_PARITY_EN
  logic [2:0] dbg_state_odd;
  uart_tx_if bus_odd ();
  uart_tx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_odd),
    .dbg_state_o (dbg_state_odd)
  );
`endif

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
`ifdef UART_TX_PARITY_EN
    if (n == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // ---------------- monitors ----------------
  int   done_cnt = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   last_gap = 0;
  logic prev_tx = 1'b1;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.tx_done === 1'b1) done_cnt++;
    if (!prev_tx && bus.tx) rise_cyc = cyc;
    if (!prev_busy && bus.tx_busy) last_gap = cyc - rise_cyc;
    prev_tx   = bus.tx;
    prev_busy = bus.tx_busy;
  end

  // ---------------- driver ----------------
  logic [10:0] mid_bits;

  task automatic send_frame(input logic [7:0] d, input bit hold, input bit poke);
    mid_bits     = '0;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) bus.tx_start = 1'b0;
      if (poke && c == 40) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h55;
      end
      if (poke && c == 41) bus.tx_start = 1'b0;
      if (c % CPB == CPB / 2) mid_bits[c / CPB] = bus.tx;
      check($sformatf("tx_%02h_c%0d", d, c), bus.tx, exp_bit(d, c / CPB));
      check($sformatf("busy_%02h_c%0d", d, c), bus.tx_busy, 1'b1);
      check($sformatf("done_%02h_c%0d", d, c), bus.tx_done, 1'b0);
    end
    @(negedge clk);
    check($sformatf("done_pulse_%02h", d), bus.tx_done, 1'b1);
    check($sformatf("busy_end_%02h", d), bus.tx_busy, 1'b0);
    check($sformatf("tx_end_%02h", d), bus.tx, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int snap;

  initial begin
    reset        = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
`ifdef UART_TX_PARITY_EN
    bus_odd.tx_start = 1'b0;
    bus_odd.tx_data  = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_busy", bus.tx_busy, 1'b0);
    check("rst_done", bus.tx_done, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame 0xAD
    snap = done_cnt;
    send_frame(8'hAD, 1'b0, 1'b0);
    check("mid_AD", mid_bits, EXP_AD);
    repeat (2) @(negedge clk);
    check("done_once_AD", done_cnt - snap, 1);
    check("done_cleared_AD", bus.tx_done, 1'b0);

    // All-zero data: parity bit 0
    send_frame(8'h00, 1'b0, 1'b0);
    check("mid_00", mid_bits, EXP_00);
    repeat (4) @(negedge clk);

    // Start while busy is ignored; no second frame follows
    snap = done_cnt;
    send_frame(8'hAD, 1'b0, 1'b1);
    check("mid_AD_poked", mid_bits, EXP_AD);
    repeat (40) @(negedge clk);
    check("idle_tx_after_poke", bus.tx, 1'b1);
    check("idle_busy_after_poke", bus.tx_busy, 1'b0);
    check("done_once_poke", done_cnt - snap, 1);

    // Back-to-back frames with tx_start held high
    send_frame(8'h0F, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("mid_F0", mid_bits, EXP_F0);
    check("b2b_high_gap", last_gap, CPB + 1);
    repeat (4) @(negedge clk);

    // Reset mid-frame
    bus.tx_data  = 8'hAD;
    bus.tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_start = 1'b0;
    repeat (60) @(negedge clk);
    snap  = done_cnt;
    reset = 1'b0;
    #1;
    check("midrst_tx", bus.tx, 1'b1);
    check("midrst_busy", bus.tx_busy, 1'b0);
    check("midrst_done", bus.tx_done, 1'b0);
    check("midrst_state", dbg_state, 3'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (FRAME + 20) @(negedge clk);
    check("postrst_tx", bus.tx, 1'b1);
    check("postrst_busy", bus.tx_busy, 1'b0);
    check("postrst_no_done", done_cnt - snap, 0);
    send_frame(8'h3C, 1'b0, 1'b0);
    check("mid_3C", mid_bits, EXP_3C);
    repeat (4) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    // Odd parity over zero data gives a 1 in the parity slot
    bus_odd.tx_data  = 8'h00;
    bus_odd.tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_odd.tx_start = 1'b0;
    check("odd_start", bus_odd.tx, 1'b0);
    repeat (9 * CPB + CPB / 2) @(negedge clk);
    check("odd_parity_00", bus_odd.tx, 1'b1);
    repeat (FRAME - (9 * CPB + CPB / 2)) @(negedge clk);
    check("odd_done", bus_odd.tx_done, 1'b1);
    check("odd_busy_end", bus_odd.tx_busy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
